branch_predictor: RTL and testbench
===================================

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter ENTRIES, default 16, number of BHT/BTB entries; power of two, 2..64; IW = log2(ENTRIES).
REQ-002 Parameter CNTW, default 16, width of the statistics counters.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 IF_PC  input  32  fetch-stage PC to look up.
REQ-006 PredictTaken  output  1  prediction for IF_PC; combinational from the stored state.
REQ-007 PredictTarget  output  32  predicted next PC for IF_PC.
REQ-008 Update  input  1  a conditional branch is resolved in EX this cycle.
REQ-009 EX_PC  input  32  PC of the resolving branch.
REQ-010 EX_Target  input  32  computed branch target.
REQ-011 BranchTaken  input  1  actual outcome from the branch comparator.
REQ-012 EX_PredTaken  input  1  prediction that was made for this branch, carried down the pipeline.
REQ-013 EX_PredTarget  input  32  predicted target that was carried down the pipeline.
REQ-014 Mispredict  output  1  combinational flush/redirect request.
REQ-015 BranchCount  output  CNTW  number of resolved branches.
REQ-016 MispredictCount  output  CNTW  number of mispredictions.

Function
REQ-017 Each entry SHALL hold valid (1b), tag (PC[31:IW+2]), ctr (2b saturating), and target (32b); index = PC[IW+1:2].
REQ-018 Hit SHALL be asserted when the indexed entry is valid and its stored tag equals the PC tag.
REQ-019 PredictTaken SHALL equal hit(IF_PC) AND ctr[1].
REQ-020 PredictTarget SHALL be the stored target when PredictTaken=1; otherwise IF_PC+4, with the 32-bit add wrapping modulo 2^32.
REQ-021 Mispredict SHALL equal Update AND ((EX_PredTaken != BranchTaken) OR (BranchTaken AND EX_PredTarget != EX_Target)).
REQ-022 Mispredict SHALL be 0 whenever Update=0, regardless of the other inputs.
REQ-023 On an Update edge with an EX_PC hit, ctr SHALL be incremented when BranchTaken=1 and decremented when BranchTaken=0.
REQ-024 ctr SHALL saturate at 2'b11 and at 2'b00.
REQ-025 On an Update edge with an EX_PC hit and BranchTaken=1, target SHALL be written with EX_Target.
REQ-026 On an Update edge with an EX_PC miss and BranchTaken=1, the entry SHALL be allocated: valid=1, tag from EX_PC, target=EX_Target, ctr=2'b10; any previous occupant is overwritten.
REQ-027 On an Update edge with an EX_PC miss and BranchTaken=0, the entry state SHALL be left unchanged.
REQ-028 Update latency SHALL be one cycle: a lookup in the cycle after the Update edge sees the new state.
REQ-029 A lookup in the same cycle as an update to the same index SHALL see the pre-update state; there is no bypass.
REQ-030 On each Update edge, BranchCount SHALL be incremented by 1.
REQ-031 When Mispredict=1 on an Update edge, MispredictCount SHALL also be incremented by 1.
REQ-032 BranchCount and MispredictCount SHALL saturate at all-ones and never wrap.
REQ-033 Only one update per cycle SHALL be supported; lookup is unrestricted and stateless.

Reset
REQ-034 While rst_n=0, independent of clk: all valid bits, all ctr, all target, BranchCount and MispredictCount SHALL be 0.
REQ-035 During reset, PredictTaken SHALL be 0 and PredictTarget SHALL be IF_PC+4.
REQ-036 When reset is asserted in the same cycle as Update, reset SHALL win and no entry or counter SHALL change.
REQ-037 After rst_n deasserts, the first rising edge SHALL perform normal updates.

Verification
REQ-038 Reset, then IF_PC=0x100 -> PredictTaken=0, PredictTarget=0x104, counters 0.
REQ-039 Update EX_PC=0x100, BranchTaken=1, EX_Target=0x80, EX_PredTaken=0 -> Mispredict=1; next cycle IF_PC=0x100 gives PredictTaken=1, PredictTarget=0x80; BranchCount=1, MispredictCount=1.
REQ-040 Continue from REQ-039 with two not-taken updates at 0x100 (preds 1 then 0) -> ctr 10->01->00, PredictTaken=0 after the first; MispredictCount=2.
REQ-041 Alias: with ENTRIES=16, allocate 0x100 taken, then resolve 0x140 taken, target 0x200 -> 0x100 now misses (PredictTarget=0x104) and 0x140 predicts 0x200.
REQ-042 Target change: hit entry, taken, EX_PredTarget=0x80, EX_Target=0x90 -> Mispredict=1, stored target becomes 0x90.
REQ-043 Force BranchCount to all-ones via CNTW=4 and 16 updates -> holds at 0xF; assert rst_n=0 mid-cycle with Update=1 -> all outputs cleared immediately.

Source files
------------

// File: rtl/branch_predictor.sv
// Direct-mapped branch predictor: a combined BHT/BTB with 2-bit saturating
// counters and per-entry targets. Lookups and mispredict detection are
// combinational. Updates commit on the rising edge. Two saturating statistics
// counters track resolved branches and mispredictions.
module branch_predictor #(
    parameter int ENTRIES = 16,
    parameter int CNTW    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      IF_PC,
    output logic             PredictTaken,
    output logic [31:0]      PredictTarget,
    input  logic             Update,
    input  logic [31:0]      EX_PC,
    input  logic [31:0]      EX_Target,
    input  logic             BranchTaken,
    input  logic             EX_PredTaken,
    input  logic [31:0]      EX_PredTarget,
    output logic             Mispredict,
    output logic [CNTW-1:0]  BranchCount,
    output logic [CNTW-1:0]  MispredictCount
);

    localparam int IW = $clog2(ENTRIES);
    localparam int TW = 30 - IW;

    // Entry storage
    logic [ENTRIES-1:0] r_valid;
    logic [TW-1:0]      r_tag    [0:ENTRIES-1];
    logic [1:0]         r_ctr    [0:ENTRIES-1];
    logic [31:0]        r_target [0:ENTRIES-1];

    // Statistics
    logic [CNTW-1:0]    r_branch_cnt;
    logic [CNTW-1:0]    r_mispred_cnt;

    // Fetch-side lookup
    logic [IW-1:0]      w_if_idx;
    logic [TW-1:0]      w_if_tag;
    logic               w_if_hit;

    // Execute-side lookup and update
    logic [IW-1:0]      w_ex_idx;
    logic [TW-1:0]      w_ex_tag;
    logic               w_ex_hit;
    logic [1:0]         w_ctr_next;
    logic               w_mispredict;
    logic               w_branch_sat;
    logic               w_mispred_sat;

    // The two low PC bits are always 00 for aligned instructions and carry
    // no information for indexing or tagging.
    logic               w_unused_pc_bits;
    assign w_unused_pc_bits = &{1'b0, IF_PC[1:0], EX_PC[1:0]};

    assign w_if_idx = IF_PC[IW+1:2];
    assign w_if_tag = IF_PC[31:IW+2];
    assign w_ex_idx = EX_PC[IW+1:2];
    assign w_ex_tag = EX_PC[31:IW+2];

    assign w_if_hit = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
    assign w_ex_hit = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);

    // Fetch prediction: stored target only when the entry predicts taken.
    // Lookup reads stored state directly, so a same-cycle update is not seen.
    always_comb begin
        PredictTaken = w_if_hit & r_ctr[w_if_idx][1];
        if (PredictTaken) begin
            PredictTarget = r_target[w_if_idx];
        end else begin
            PredictTarget = IF_PC + 32'd4;
        end
    end

    // Mispredict: wrong direction, or taken with a wrong carried target.
    always_comb begin
        if (Update) begin
            w_mispredict = (EX_PredTaken != BranchTaken) ||
                           (BranchTaken && (EX_PredTarget != EX_Target));
        end else begin
            w_mispredict = 1'b0;
        end
    end

    assign Mispredict = w_mispredict;

    // Next counter value for the resolving entry, saturating at both ends.
    always_comb begin
        w_ctr_next = r_ctr[w_ex_idx];
        if (BranchTaken) begin
            if (r_ctr[w_ex_idx] != 2'b11) begin
                w_ctr_next = r_ctr[w_ex_idx] + 2'b01;
            end else begin
                w_ctr_next = 2'b11;
            end
        end else begin
            if (r_ctr[w_ex_idx] != 2'b00) begin
                w_ctr_next = r_ctr[w_ex_idx] - 2'b01;
            end else begin
                w_ctr_next = 2'b00;
            end
        end
    end

    assign w_branch_sat  = &r_branch_cnt;
    assign w_mispred_sat = &r_mispred_cnt;

    // Table update: train on hits, allocate on taken misses, ignore
    // not-taken misses so cold branches do not evict useful entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= {ENTRIES{1'b0}};
            for (int i = 0; i < ENTRIES; i++) begin
                r_tag[i]    <= {TW{1'b0}};
                r_ctr[i]    <= 2'b00;
                r_target[i] <= 32'd0;
            end
        end else if (Update) begin
            if (w_ex_hit) begin
                r_ctr[w_ex_idx] <= w_ctr_next;
                if (BranchTaken) begin
                    r_target[w_ex_idx] <= EX_Target;
                end
            end else if (BranchTaken) begin
                r_valid[w_ex_idx]  <= 1'b1;
                r_tag[w_ex_idx]    <= w_ex_tag;
                r_ctr[w_ex_idx]    <= 2'b10;
                r_target[w_ex_idx] <= EX_Target;
            end
        end
    end

    // Statistics counters, saturating at all-ones so they never wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_branch_cnt  <= {CNTW{1'b0}};
            r_mispred_cnt <= {CNTW{1'b0}};
        end else if (Update) begin
            if (!w_branch_sat) begin
                r_branch_cnt <= r_branch_cnt + {{(CNTW-1){1'b0}}, 1'b1};
            end
            if (w_mispredict && !w_mispred_sat) begin
                r_mispred_cnt <= r_mispred_cnt + {{(CNTW-1){1'b0}}, 1'b1};
            end
        end
    end

    assign BranchCount     = r_branch_cnt;
    assign MispredictCount = r_mispred_cnt;

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed vector table, randomized traffic
// against a behavioural model, and asynchronous-reset corner cases. A second
// instance with 4-bit statistics counters exercises counter saturation.
module tb_branch_predictor;

    localparam int ENT = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] if_pc, ex_pc, ex_tgt, ex_ptgt;
    logic        upd, tk, ptk;

    logic        pt, mp, pt4, mp4;
    logic [31:0] ptgt, ptgt4;
    logic [15:0] bc, mc;
    logic [3:0]  bc4, mc4;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    branch_predictor #(.ENTRIES(16), .CNTW(16)) dut (
        .clk(clk), .rst_n(rst_n), .IF_PC(if_pc),
        .PredictTaken(pt), .PredictTarget(ptgt),
        .Update(upd), .EX_PC(ex_pc), .EX_Target(ex_tgt),
        .BranchTaken(tk), .EX_PredTaken(ptk), .EX_PredTarget(ex_ptgt),
        .Mispredict(mp), .BranchCount(bc), .MispredictCount(mc)
    );

    branch_predictor #(.ENTRIES(16), .CNTW(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .IF_PC(if_pc),
        .PredictTaken(pt4), .PredictTarget(ptgt4),
        .Update(upd), .EX_PC(ex_pc), .EX_Target(ex_tgt),
        .BranchTaken(tk), .EX_PredTaken(ptk), .EX_PredTarget(ex_ptgt),
        .Mispredict(mp4), .BranchCount(bc4), .MispredictCount(mc4)
    );

    // ---------------- behavioural model ----------------
    bit          m_valid [ENT];
    logic [31:0] m_tag   [ENT];
    int          m_ctr   [ENT];
    logic [31:0] m_tgt   [ENT];
    int          m_bc, m_mc;

    function automatic int m_idx(input logic [31:0] pc);
        return int'((pc >> 2) % ENT);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_valid[m_idx(pc)] && (m_tag[m_idx(pc)] == (pc >> 6));
    endfunction

    function automatic bit m_pt(input logic [31:0] pc);
        return m_hit(pc) && (m_ctr[m_idx(pc)] >= 2);
    endfunction

    function automatic logic [31:0] m_ptgt(input logic [31:0] pc);
        return m_pt(pc) ? m_tgt[m_idx(pc)] : pc + 32'd4;
    endfunction

    function automatic bit m_mp();
        return upd && ((ptk != tk) || (tk && ex_ptgt != ex_tgt));
    endfunction

    task automatic m_reset();
        for (int i = 0; i < ENT; i++) begin
            m_valid[i] = 0; m_tag[i] = 32'd0; m_ctr[i] = 0; m_tgt[i] = 32'd0;
        end
        m_bc = 0; m_mc = 0;
    endtask

    // Applies the resolving branch currently on the inputs.
    task automatic m_update();
        int i;
        if (upd) begin
            i = m_idx(ex_pc);
            m_bc++;
            if (m_mp()) m_mc++;
            if (m_hit(ex_pc)) begin
                m_ctr[i] = tk ? ((m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1)
                              : ((m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1);
                if (tk) m_tgt[i] = ex_tgt;
            end else if (tk) begin
                m_valid[i] = 1; m_tag[i] = ex_pc >> 6; m_ctr[i] = 2; m_tgt[i] = ex_tgt;
            end
        end
    endtask

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic u, input logic [31:0] ip, input logic [31:0] ep,
                         input logic [31:0] et, input logic t, input logic p,
                         input logic [31:0] pg);
        upd = u; if_pc = ip; ex_pc = ep; ex_tgt = et; tk = t; ptk = p; ex_ptgt = pg;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        u;
        logic [31:0] ip, ep, et;
        logic        t, p;
        logic [31:0] pg;
        logic        e_pt;
        logic [31:0] e_ptgt;
        logic        e_mp;
        int          e_bc, e_mc;
    } vec_t;

    function automatic vec_t mk(input logic u, input logic [31:0] ip, input logic [31:0] ep,
                                input logic [31:0] et, input logic t, input logic p,
                                input logic [31:0] pg, input logic e_pt,
                                input logic [31:0] e_ptgt, input logic e_mp,
                                input int e_bc, input int e_mc);
        vec_t v;
        v.u = u; v.ip = ip; v.ep = ep; v.et = et; v.t = t; v.p = p; v.pg = pg;
        v.e_pt = e_pt; v.e_ptgt = e_ptgt; v.e_mp = e_mp; v.e_bc = e_bc; v.e_mc = e_mc;
        return v;
    endfunction

    function automatic logic [31:0] rand_pc();
        logic [31:0] hi, lo;
        lo = 32'($urandom_range(0, 15)) << 2;
        if ($urandom_range(0, 9) == 0) begin
            hi = 32'hFFFF_FFC0;
        end else begin
            hi = 32'($urandom_range(0, 3)) << 6;
        end
        return hi | lo;
    endfunction

    vec_t vecs[18];

    initial begin
        logic [31:0] rp, rq;

        //        u     IF_PC          EX_PC         EX_Tgt        tk    ptk   PredTgt       e_pt  e_ptgt         e_mp  bc mc
        vecs[0]  = mk(1'b0, 32'h100,       32'h0,        32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 32'h104,       1'b0, 0, 0);
        vecs[1]  = mk(1'b1, 32'h100,       32'h100,      32'h80,       1'b1, 1'b0, 32'h104,      1'b0, 32'h104,       1'b1, 1, 1);
        vecs[2]  = mk(1'b0, 32'h100,       32'h0,        32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 32'h80,        1'b0, 1, 1);
        vecs[3]  = mk(1'b1, 32'h100,       32'h100,      32'h80,       1'b0, 1'b1, 32'h80,       1'b1, 32'h80,        1'b1, 2, 2);
        vecs[4]  = mk(1'b1, 32'h100,       32'h100,      32'h80,       1'b0, 1'b0, 32'h104,      1'b0, 32'h104,       1'b0, 3, 2);
        vecs[5]  = mk(1'b0, 32'h100,       32'h0,        32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 32'h104,       1'b0, 3, 2);
        vecs[6]  = mk(1'b1, 32'h100,       32'h100,      32'h80,       1'b1, 1'b0, 32'h104,      1'b0, 32'h104,       1'b1, 4, 3);
        vecs[7]  = mk(1'b1, 32'h100,       32'h100,      32'h80,       1'b1, 1'b0, 32'h104,      1'b0, 32'h104,       1'b1, 5, 4);
        vecs[8]  = mk(1'b0, 32'h100,       32'h0,        32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 32'h80,        1'b0, 5, 4);
        vecs[9]  = mk(1'b1, 32'h100,       32'h100,      32'h90,       1'b1, 1'b1, 32'h80,       1'b1, 32'h80,        1'b1, 6, 5);
        vecs[10] = mk(1'b0, 32'h100,       32'h0,        32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 32'h90,        1'b0, 6, 5);
        vecs[11] = mk(1'b1, 32'h100,       32'h100,      32'h90,       1'b1, 1'b1, 32'h90,       1'b1, 32'h90,        1'b0, 7, 5);
        vecs[12] = mk(1'b1, 32'h140,       32'h140,      32'h200,      1'b1, 1'b0, 32'h144,      1'b0, 32'h144,       1'b1, 8, 6);
        vecs[13] = mk(1'b0, 32'h100,       32'h0,        32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 32'h104,       1'b0, 8, 6);
        vecs[14] = mk(1'b0, 32'h140,       32'h0,        32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 32'h200,       1'b0, 8, 6);
        vecs[15] = mk(1'b1, 32'h140,       32'h100,      32'h80,       1'b0, 1'b0, 32'h104,      1'b1, 32'h200,       1'b0, 9, 6);
        vecs[16] = mk(1'b0, 32'h140,       32'h0,        32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 32'h200,       1'b0, 9, 6);
        vecs[17] = mk(1'b0, 32'hFFFF_FFFC, 32'h100,      32'h2,        1'b1, 1'b0, 32'h1,        1'b0, 32'h0,         1'b0, 9, 6);

        rst_n = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        m_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed table: prediction before the edge, counters after it.
        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].u, vecs[i].ip, vecs[i].ep, vecs[i].et, vecs[i].t, vecs[i].p, vecs[i].pg);
            #1;
            check($sformatf("vec%0d PredictTaken", i), {31'd0, pt}, {31'd0, vecs[i].e_pt});
            check($sformatf("vec%0d PredictTarget", i), ptgt, vecs[i].e_ptgt);
            check($sformatf("vec%0d Mispredict", i), {31'd0, mp}, {31'd0, vecs[i].e_mp});
            @(posedge clk);
            m_update();
            #1;
            check($sformatf("vec%0d BranchCount", i), {16'd0, bc}, 32'(vecs[i].e_bc));
            check($sformatf("vec%0d MispredictCount", i), {16'd0, mc}, 32'(vecs[i].e_mc));
            check($sformatf("vec%0d BranchCount4", i), {28'd0, bc4}, 32'(sat(vecs[i].e_bc, 15)));
        end

        // Randomized traffic against the model.
        for (int n = 0; n < 300; n++) begin
            rp = rand_pc();
            rq = ($urandom_range(0, 3) == 0) ? rp : rand_pc();
            drive(($urandom_range(0, 3) != 0), rq, rp, {$urandom} & 32'hFFFF_FFFC,
                  1'($urandom_range(0, 1)), 1'b0, 32'h0);
            if ($urandom_range(0, 1) == 1) begin
                ptk = m_pt(rp); ex_ptgt = m_ptgt(rp);
            end else begin
                ptk = 1'($urandom_range(0, 1));
                ex_ptgt = ($urandom_range(0, 1) == 1) ? ex_tgt : rp + 32'd4;
            end
            #1;
            check($sformatf("rnd%0d PredictTaken", n), {31'd0, pt}, {31'd0, m_pt(if_pc)});
            check($sformatf("rnd%0d PredictTarget", n), ptgt, m_ptgt(if_pc));
            check($sformatf("rnd%0d Mispredict", n), {31'd0, mp}, {31'd0, m_mp()});
            @(posedge clk);
            m_update();
            #1;
            check($sformatf("rnd%0d BranchCount", n), {16'd0, bc}, 32'(sat(m_bc, 65535)));
            check($sformatf("rnd%0d MispredictCount", n), {16'd0, mc}, 32'(sat(m_mc, 65535)));
            check($sformatf("rnd%0d BranchCount4", n), {28'd0, bc4}, 32'(sat(m_bc, 15)));
            check($sformatf("rnd%0d MispredictCount4", n), {28'd0, mc4}, 32'(sat(m_mc, 15)));
        end
        check("cnt4 saturated", {28'd0, bc4}, 32'hF);

        // Asynchronous reset mid-cycle while an update is pending.
        drive(1'b1, 32'h300, 32'h300, 32'h400, 1'b1, 1'b1, 32'h400);
        #2 rst_n = 1'b0;
        #1;
        check("rst async PredictTaken", {31'd0, pt}, 32'd0);
        check("rst async PredictTarget", ptgt, 32'h304);
        check("rst async BranchCount", {16'd0, bc}, 32'd0);
        check("rst async MispredictCount", {16'd0, mc}, 32'd0);
        check("rst async BranchCount4", {28'd0, bc4}, 32'd0);
        check("rst async MispredictCount4", {28'd0, mc4}, 32'd0);
        m_reset();
        @(posedge clk);
        #1;
        check("rst wins PredictTaken", {31'd0, pt}, 32'd0);
        check("rst wins BranchCount", {16'd0, bc}, 32'd0);
        // Release between edges; the next edge must update normally.
        #3 rst_n = 1'b1;
        #1;
        check("post-rst pre-edge PredictTaken", {31'd0, pt}, 32'd0);
        check("post-rst Mispredict", {31'd0, mp}, 32'd0);
        @(posedge clk);
        m_update();
        #1;
        check("post-rst PredictTaken", {31'd0, pt}, 32'd1);
        check("post-rst PredictTarget", ptgt, 32'h400);
        check("post-rst BranchCount", {16'd0, bc}, 32'd1);
        check("post-rst MispredictCount", {16'd0, mc}, 32'd0);
        check("post-rst model PredictTarget", ptgt, m_ptgt(32'h300));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
